alu_exec_ctrl: RTL
==================

Name: alu_exec_ctrl

Overview:
Execute-stage controller that sits upstream of the combinational ALU and drives its operand and control inputs. It decodes ALUOp/funct3/funct7[5] into the 4-bit ALU control code and consumes ALU_Result/zero. It also resolves RV32I branches and registers the outcome. The block is a 2-stage valid/ready pipeline (operand register -> result register) between decode and memory stages.

Parameters:
XLEN, 32, datapath width (A, B, result, pc, imm)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  decode offers an operation
in_ready  output  1  controller accepts when in_valid&in_ready
ALUOp  input  2  00 load/store add, 01 branch, 10 R-type, 11 I-type ALU
funct3  input  3  instruction funct3
funct7b5  input  1  instruction bit 30
ALUSrc  input  1  1: B=imm, 0: B=rs2_data (ignored for branch, forced 0)
rs1_data  input  XLEN  operand A
rs2_data  input  XLEN  register operand B
imm  input  XLEN  sign-extended immediate
pc  input  XLEN  instruction address
alu_A  output  XLEN  to ALU A
alu_B  output  XLEN  to ALU B
alu_Control  output  4  to ALU Control_in
alu_Result  input  XLEN  from ALU ALU_Result
alu_zero  input  1  from ALU zero
out_valid  output  1  result register holds an operation
out_ready  input  1  downstream accepts when out_valid&out_ready
out_result  output  XLEN  registered ALU result
out_branch_taken  output  1  registered branch decision
out_branch_target  output  XLEN  registered pc+imm
out_illegal  output  1  registered undefined-encoding flag

Behaviour:
- Reset (async, immediate): s1_valid=0, out_valid=0, stage-1 register contents=0 (alu_A=0, alu_B=0, alu_Control=4'b0000), out_result=0, out_branch_taken=0, out_branch_target=0, out_illegal=0. The operation in flight is discarded with no partial output.
- Control codes: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SLT 0111, SLTU 1000, SRA 1001.
- Decode on accept, registered into stage 1 together with target=pc+imm (XLEN-bit wrap), is_branch, funct3, and illegal.
  - ALUOp 00: ADD, B per ALUSrc.
  - ALUOp 10 by funct3:
    - 000: funct7b5 ? SUB : ADD
    - 001: SLL; 010: SLT; 011: SLTU; 100: XOR
    - 101: funct7b5 ? SRA : SRL
    - 110: OR; 111: AND
  - ALUOp 11: same as ALUOp 10, except 000 is always ADD (funct7b5 ignored).
  - ALUOp 01 (branch), B=rs2_data:
    - 000 BEQ and 001 BNE: SUB
    - 100 BLT and 101 BGE: SLT
    - 110 BLTU and 111 BGEU: SLTU
    - 010/011: illegal=1, code ADD.
- Stage 1 drives alu_A/alu_B/alu_Control from its register. The ALU is combinational, so the result is sampled in the same cycle.
- Stage 2 captures alu_Result and the branch decision:
  - BEQ: zero. BNE: !zero.
  - BLT/BLTU: alu_Result[0]. BGE/BGEU: !alu_Result[0].
  - Non-branch or illegal: taken=0.
  - Illegal: out_result=0.
- Handshake:
  - s2_load = s1_valid & (!out_valid | out_ready).
  - in_ready = !s1_valid | s2_load (combinational, no dependency on in_valid).
  - Latency: accept at edge N -> out_valid at edge N+1. Throughput is 1/cycle when out_ready=1.
- out_valid stalled (out_ready=0):
  - out_* hold stable.
  - Stage 1 holds, so alu_* inputs stay stable.
  - in_ready=0 once s1 is full.
- Simultaneous accept and drain on the same edge: both registers update, and no bubble is inserted.
- out_valid falls only when out_ready=1 and s1_valid=0.

Decomposition:
- Shared package alu_pkg holds:
  - the ten 4-bit ALU control localparams;
  - ALUOp encodings;
  - funct3 branch encodings (BEQ..BGEU).
- The ALU module is reused unchanged.
- One natural sub-module: alu_ctrl_decode, the combinational ALUOp/funct3/funct7b5 -> {control, is_branch, illegal} decoder.

Test Plan:
- R-type SUB: ALUOp=10, funct3=000, funct7b5=1, rs1=10, rs2=3 -> alu_Control=0110 in the cycle after accept. One cycle later out_result=7, out_illegal=0.
- I-type ADDI with funct7b5=1: ALUOp=11, funct3=000, ALUSrc=1, rs1=5, imm=0xFFFFFFFF -> alu_Control=0010, out_result=4 (not SUB).
- Branches with pc=0x100, imm=0x20:
  - BEQ rs1=rs2=9 -> taken=1, target=0x120.
  - BLT rs1=0xFFFFFFFF, rs2=1 -> taken=1.
  - BLTU with the same operands -> taken=0.
  - BGEU with the same operands -> taken=1.
- Backpressure: stream 4 ADDs with out_ready=0 for 3 cycles -> in_ready drops after the 2nd accept, and out_result holds the first value. Releasing out_ready returns results in order at 1/cycle with no loss or duplication.
- Illegal branch: ALUOp=01, funct3=010 -> out_illegal=1, out_result=0, taken=0.
- Reset asserted mid-stream with s1 and s2 full -> out_valid=0 and alu_Control=0000 immediately (asynchronous). After release, in_ready=1 and no stale result appears.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions for the execute stage.
// Holds the 4-bit ALU control codes, the ALUOp class encodings, the RV32I
// branch funct3 encodings and the branch-resolution helper that turns the
// ALU's zero/LSB outputs into a taken/not-taken decision.
package alu_pkg;

    // ALU control codes
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    // ALUOp instruction classes
    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

    // Branch funct3 encodings
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // BEQ/BNE look at the SUB result being zero; the less-than family looks
    // at the SLT/SLTU result bit. Undefined encodings never take.
    function automatic logic branch_resolve(input logic [2:0] f3,
                                            input logic       zero,
                                            input logic       lsb);
        logic taken;
        case (f3)
            F3_BEQ:           taken = zero;
            F3_BNE:           taken = ~zero;
            F3_BLT, F3_BLTU:  taken = lsb;
            F3_BGE, F3_BGEU:  taken = ~lsb;
            default:          taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU control decoder.
// Ports:
//   alu_op    in  2  instruction class (mem / branch / R-type / I-type)
//   funct3    in  3  instruction funct3
//   funct7b5  in  1  instruction bit 30 (SUB/SRA select)
//   control   out 4  ALU control code
//   is_branch out 1  operation is a conditional branch
//   illegal   out 1  undefined encoding (branch funct3 010/011)
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [3:0] control,
    output logic       is_branch,
    output logic       illegal
);

    // Decode instruction class and function fields into an ALU control code
    always_comb begin
        control   = ALU_ADD;
        is_branch = 1'b0;
        illegal   = 1'b0;
        case (alu_op)
            ALUOP_MEM: begin
                control = ALU_ADD;
            end
            ALUOP_BRANCH: begin
                is_branch = 1'b1;
                case (funct3)
                    F3_BEQ, F3_BNE:   control = ALU_SUB;
                    F3_BLT, F3_BGE:   control = ALU_SLT;
                    F3_BLTU, F3_BGEU: control = ALU_SLTU;
                    default: begin
                        control = ALU_ADD;
                        illegal = 1'b1;
                    end
                endcase
            end
            ALUOP_RTYPE, ALUOP_ITYPE: begin
                case (funct3)
                    // Only R-type uses bit 30 to pick SUB; ADDI ignores it
                    3'b000:  control = (funct7b5 && (alu_op == ALUOP_RTYPE)) ? ALU_SUB : ALU_ADD;
                    3'b001:  control = ALU_SLL;
                    3'b010:  control = ALU_SLT;
                    3'b011:  control = ALU_SLTU;
                    3'b100:  control = ALU_XOR;
                    3'b101:  control = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  control = ALU_OR;
                    3'b111:  control = ALU_AND;
                    default: control = ALU_ADD;
                endcase
            end
            default: begin
                control = ALU_ADD;
            end
        endcase
    end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Execute-stage controller in front of a combinational ALU.
// Stage 1 registers the decoded operation and drives the ALU inputs; stage 2
// captures the ALU result and the resolved branch outcome.
// Ports:
//   clk, reset                         clock, async active-high reset
//   in_valid/in_ready                  decode-side handshake
//   ALUOp, funct3, funct7b5, ALUSrc    decode controls
//   rs1_data, rs2_data, imm, pc        operands and instruction address
//   alu_A, alu_B, alu_Control          to the ALU
//   alu_Result, alu_zero               from the ALU
//   out_valid/out_ready                memory-side handshake
//   out_result, out_branch_taken,
//   out_branch_target, out_illegal     registered results
module alu_exec_ctrl
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      ALUOp,
    input  logic [2:0]      funct3,
    input  logic            funct7b5,
    input  logic            ALUSrc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] alu_A,
    output logic [XLEN-1:0] alu_B,
    output logic [3:0]      alu_Control,
    input  logic [XLEN-1:0] alu_Result,
    input  logic            alu_zero,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_branch_taken,
    output logic [XLEN-1:0] out_branch_target,
    output logic            out_illegal
);

    logic [3:0]      dec_control_s;
    logic            dec_is_branch_s;
    logic            dec_illegal_s;
    logic [XLEN-1:0] operand_b_s;
    logic            accept_s;
    logic            s2_load_s;
    logic            taken_s;

    logic            s1_valid_r;
    logic [XLEN-1:0] a_r;
    logic [XLEN-1:0] b_r;
    logic [3:0]      ctrl_r;
    logic [XLEN-1:0] target_r;
    logic            is_branch_r;
    logic [2:0]      funct3_r;
    logic            illegal_r;

    logic            out_valid_r;
    logic [XLEN-1:0] out_result_r;
    logic            out_taken_r;
    logic [XLEN-1:0] out_target_r;
    logic            out_illegal_r;

    alu_ctrl_decode u_decode (
        .alu_op    (ALUOp),
        .funct3    (funct3),
        .funct7b5  (funct7b5),
        .control   (dec_control_s),
        .is_branch (dec_is_branch_s),
        .illegal   (dec_illegal_s)
    );

    // Select operand B: branches always compare against rs2
    always_comb begin
        operand_b_s = rs2_data;
        if (dec_is_branch_s) begin
            operand_b_s = rs2_data;
        end else if (ALUSrc) begin
            operand_b_s = imm;
        end else begin
            operand_b_s = rs2_data;
        end
    end

    // Stage 1 empties into stage 2 whenever stage 2 is free or draining
    assign s2_load_s = s1_valid_r & (~out_valid_r | out_ready);
    assign in_ready  = ~s1_valid_r | s2_load_s;
    assign accept_s  = in_valid & in_ready;
    assign taken_s   = is_branch_r & ~illegal_r &
                       branch_resolve(funct3_r, alu_zero, alu_Result[0]);

    // Stage 1: decoded operation register feeding the ALU
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_r  <= 1'b0;
            a_r         <= {XLEN{1'b0}};
            b_r         <= {XLEN{1'b0}};
            ctrl_r      <= 4'b0000;
            target_r    <= {XLEN{1'b0}};
            is_branch_r <= 1'b0;
            funct3_r    <= 3'b000;
            illegal_r   <= 1'b0;
        end else if (accept_s) begin
            s1_valid_r  <= 1'b1;
            a_r         <= rs1_data;
            b_r         <= operand_b_s;
            ctrl_r      <= dec_control_s;
            target_r    <= pc + imm;
            is_branch_r <= dec_is_branch_s;
            funct3_r    <= funct3;
            illegal_r   <= dec_illegal_s;
        end else if (s2_load_s) begin
            s1_valid_r  <= 1'b0;
        end else begin
            s1_valid_r  <= s1_valid_r;
        end
    end

    // Stage 2: capture ALU result and branch outcome, hold while stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_r   <= 1'b0;
            out_result_r  <= {XLEN{1'b0}};
            out_taken_r   <= 1'b0;
            out_target_r  <= {XLEN{1'b0}};
            out_illegal_r <= 1'b0;
        end else if (s2_load_s) begin
            out_valid_r   <= 1'b1;
            out_result_r  <= illegal_r ? {XLEN{1'b0}} : alu_Result;
            out_taken_r   <= taken_s;
            out_target_r  <= target_r;
            out_illegal_r <= illegal_r;
        end else if (out_ready) begin
            out_valid_r   <= 1'b0;
        end else begin
            out_valid_r   <= out_valid_r;
        end
    end

    assign alu_A             = a_r;
    assign alu_B             = b_r;
    assign alu_Control       = ctrl_r;
    assign out_valid         = out_valid_r;
    assign out_result        = out_result_r;
    assign out_branch_taken  = out_taken_r;
    assign out_branch_target = out_target_r;
    assign out_illegal       = out_illegal_r;

endmodule
